// File: rtl/fifo_pkg.sv
// Shared sizing for the commit FIFO: default word/address widths and the
// wrap-bit pointer type used to address its storage.
package fifo_pkg;

  localparam int DATA_WIDTH = 9;  // 8 data bits + 1 status/parity bit
  localparam int ADDR_WIDTH = 4;  // depth = 2**ADDR_WIDTH entries

  // Pointer with one extra wrap bit so full and empty can be told apart
  typedef logic [ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// The read register is resettable so the FIFO output starts from zero.
module fifo_ram #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: storage contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/commit_fifo.sv
// Transactional single-clock FIFO. Writes land behind a tentative pointer;
// commit publishes them to the reader, rollback discards them. The reader
// only ever sees entries between rd_ptr and commit_ptr.
module commit_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEn,
  input  logic                  commitWrite,
  input  logic                  rollbackWrite,
  input  logic                  readEn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0] commit_ptr_reg, commit_ptr_next;
  logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
  logic                data_valid_reg, overflow_reg;
  logic                overflow_next;
  logic                wr_fire, rd_fire;

  // Flags come straight from the registered pointers
  assign empty = (rd_ptr_reg == commit_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                 (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);

  // A write in a rollback cycle is simply discarded, so it never overflows
  assign wr_fire       = writeEn && !full && !rollbackWrite;
  assign overflow_next = writeEn &&  full && !rollbackWrite;
  assign rd_fire       = readEn && !empty;

  // Next-pointer logic: rollback beats commit; commit includes this cycle's write
  always_comb begin
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    if (rd_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    if (rollbackWrite) begin
      wr_ptr_next = commit_ptr_reg;
    end else begin
      if (wr_fire) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (commitWrite) begin
        commit_ptr_next = wr_ptr_next;
      end
    end
  end

  // Pointer and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      wr_ptr_reg     <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      data_valid_reg <= rd_fire;
      overflow_reg   <= overflow_next;
    end
  end

  assign dataValid = data_valid_reg;
  assign overflow  = overflow_reg;

  // Storage; its read register doubles as the dataOut holding register
  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .srst   (reset),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data(dataIn),
    .rd_en  (rd_fire),
    .rd_addr(rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data(dataOut)
  );

endmodule

// File: tb/tb_commit_fifo.sv
// Bench for commit_fifo: directed scenarios plus random traffic, all
// checked against a queue-based model of committed and pending words.
module tb_commit_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [DATA_WIDTH-1:0] dataIn = '0;
  logic                  writeEn = 1'b0;
  logic                  commitWrite = 1'b0;
  logic                  rollbackWrite = 1'b0;
  logic                  readEn = 1'b0;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  empty;
  logic                  full;
  logic                  overflow;

  commit_fifo dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .writeEn(writeEn),
    .commitWrite(commitWrite), .rollbackWrite(rollbackWrite), .readEn(readEn),
    .dataOut(dataOut), .dataValid(dataValid), .empty(empty), .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed words visible to reader, pending tentative words
  logic [DATA_WIDTH-1:0] cq[$];
  logic [DATA_WIDTH-1:0] pq[$];
  logic [DATA_WIDTH-1:0] last_data = '0;
  logic [DATA_WIDTH-1:0] got[$];  // words actually read out by the DUT

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; model computed from pre-edge state, outputs checked after the edge
  task automatic cycle(input logic [DATA_WIDTH-1:0] d, input logic we, input logic cm,
                       input logic rb, input logic re);
    bit exp_valid, exp_ovf, full_pre;
    dataIn = d; writeEn = we; commitWrite = cm; rollbackWrite = rb; readEn = re;
    full_pre  = (cq.size() + pq.size() == DEPTH);
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    if (re && cq.size() > 0) begin
      last_data = cq.pop_front();
      exp_valid = 1'b1;
    end
    if (rb) begin
      pq.delete();
    end else begin
      if (we) begin
        if (full_pre) exp_ovf = 1'b1;
        else pq.push_back(d);
      end
      if (cm) begin
        foreach (pq[k]) cq.push_back(pq[k]);
        pq.delete();
      end
    end
    @(posedge clk);
    #1;
    check("dataValid", dataValid, exp_valid);
    check("overflow", overflow, exp_ovf);
    check("dataOut", dataOut, last_data);
    check("empty", empty, cq.size() == 0);
    check("full", full, (cq.size() + pq.size()) == DEPTH);
    if (dataValid) begin
      got.push_back(dataOut);
      $display("read 0x%03h", dataOut);
    end
  endtask

  task automatic idle(input int n, input logic re);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0, 1'b0, re);
  endtask

  task automatic do_reset();
    dataIn = '0; writeEn = 1'b0; commitWrite = 1'b0; rollbackWrite = 1'b0; readEn = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cq.delete(); pq.delete(); last_data = '0; got.delete();
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_dataOut", dataOut, 0);
    check("rst_dataValid", dataValid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    $display("reset applied");
  endtask

  // Compare captured read sequence against an explicit expected list
  task automatic check_got(input string tag, input logic [DATA_WIDTH-1:0] exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] exp[$];

    // 1: reset
    do_reset();

    // 2: uncommitted word is invisible until commit
    cycle(9'h118, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("s2_hidden_empty", empty, 1'b1);
    end
    cycle('0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("s2_commit_empty", empty, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s2_valid", dataValid, 1'b1);
    check("s2_data", dataOut, 9'h118);
    check("s2_drained", empty, 1'b1);
    exp = '{9'h118};
    check_got("s2_seq", exp);

    // 3: rollback discards pending word
    cycle(9'h164, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(9'h0AA, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    check("s3_empty", empty, 1'b1);
    exp = '{9'h0AA};
    check_got("s3_seq", exp);

    // 4: same-cycle combinations
    cycle(9'h055, 1'b1, 1'b1, 1'b0, 1'b0);
    check("s4_wc_empty", empty, 1'b0);
    idle(3, 1'b1);
    cycle(9'h0F0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    cycle(9'h001, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    check("s4_empty", empty, 1'b1);
    exp = '{9'h055};
    check_got("s4_seq", exp);

    // 5: fill, overflow, commit, drain
    for (int i = 0; i < DEPTH; i++) cycle(9'h100 + 9'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("s5_full", full, 1'b1);
    cycle(9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s5_overflow", overflow, 1'b1);
    cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s5_ovf_cleared", overflow, 1'b0);
    idle(DEPTH + 2, 1'b1);
    check("s5_empty", empty, 1'b1);
    exp.delete();
    for (int i = 0; i < DEPTH; i++) exp.push_back(9'h100 + 9'(i));
    check_got("s5_seq", exp);

    // 6: wrap-around streaming, then reset mid-stream
    for (int i = 0; i < 50; i++) cycle(9'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    exp.delete();
    for (int i = 0; i < 50; i++) exp.push_back(9'(i));
    check_got("s6_seq", exp);
    for (int i = 0; i < 5; i++) cycle(9'h080 + 9'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle(4, 1'b1);
    check("s6_post_rst_empty", empty, 1'b1);
    exp.delete();
    check_got("s6_post_rst", exp);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(9'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4));
    end
    idle(DEPTH + 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
